ex_mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. It consumes the operand, ALU-control and write-back fields driven by the ID/EX pipeline register and executes RV32M operations iteratively, one bit per cycle. It holds the ID/EX register with a stall request while it computes. It returns a one-cycle result beat with the latched write-back address and enable.

---
 rtl/ex_mdu.sv | 238 +++++++++++++++++++++++
 tb/tb_ex_mdu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage: one bit per cycle,
// stalling ID/EX while busy and emitting a single-cycle result beat.
module ex_mdu #(
    parameter logic [4:0] MDU_BASE = 5'd16,
    parameter int         XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] id_ex_reg_op_a_i,
    input  logic [XLEN-1:0] id_ex_reg_op_b_i,
    input  logic [4:0]      id_ex_reg_ALUctrl_i,
    input  logic [4:0]      id_ex_reg_reg_waddr_i,
    input  logic            id_ex_reg_reg_we_i,
    input  logic            ex_flush_i,
    output logic            ex_mdu_stall_o,
    output logic            ex_mdu_busy_o,
    output logic            ex_mdu_valid_o,
    output logic [XLEN-1:0] ex_mdu_result_o,
    output logic [4:0]      ex_mdu_reg_waddr_o,
    output logic            ex_mdu_reg_we_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    function automatic logic [XLEN-1:0] neg_w(input logic en, input logic [XLEN-1:0] v);
        return en ? ({XLEN{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic en, input logic [2*XLEN-1:0] v);
        return en ? ({(2*XLEN){1'b0}} - v) : v;
    endfunction

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [4:0]          waddr_q, waddr_d;
    logic                we_q, we_d;
    logic                valid_q, valid_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          waddr_out_q, waddr_out_d;
    logic                we_out_q, we_out_d;

    logic [4:0]          ctrl_off_s;
    logic                is_mdu_s;
    logic [2:0]          op_in_s;
    logic                a_signed_s, b_signed_s;
    logic                a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;

    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       rem_sh_s;
    logic [XLEN:0]       diff_s;
    logic [2*XLEN-1:0]   acc_step_s;
    logic [2*XLEN-1:0]   fin_prod_s;
    logic [XLEN-1:0]     fin_res_s;

    // Decode the incoming op: range check, signedness, magnitudes, special cases.
    always_comb begin
        ctrl_off_s    = id_ex_reg_ALUctrl_i - MDU_BASE;
        is_mdu_s      = (ctrl_off_s < 5'd8);
        op_in_s       = ctrl_off_s[2:0];
        a_signed_s    = (op_in_s == OP_MULH) || (op_in_s == OP_MULHSU) ||
                        (op_in_s == OP_DIV)  || (op_in_s == OP_REM);
        b_signed_s    = (op_in_s == OP_MULH) || (op_in_s == OP_DIV) || (op_in_s == OP_REM);
        a_neg_s       = a_signed_s & id_ex_reg_op_a_i[XLEN-1];
        b_neg_s       = b_signed_s & id_ex_reg_op_b_i[XLEN-1];
        a_mag_s       = neg_w(a_neg_s, id_ex_reg_op_a_i);
        b_mag_s       = neg_w(b_neg_s, id_ex_reg_op_b_i);
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
        if (op_in_s[2] && (id_ex_reg_op_b_i == {XLEN{1'b0}})) begin
            special_s     = 1'b1;
            special_res_s = op_in_s[1] ? id_ex_reg_op_a_i : {XLEN{1'b1}};
        end else if (((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                     (id_ex_reg_op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (id_ex_reg_op_b_i == {XLEN{1'b1}})) begin
            special_s     = 1'b1;
            special_res_s = op_in_s[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end else begin
            special_s     = 1'b0;
        end
    end

    // One iteration: shift-add for multiply, restore-or-subtract for divide.
    always_comb begin
        sum_s    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
        rem_sh_s = acc_q[2*XLEN-1:XLEN-1];
        diff_s   = rem_sh_s - {1'b0, b_q};
        if (op_q[2]) begin
            if (diff_s[XLEN]) begin
                acc_step_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_step_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step_s = {sum_s, acc_q[XLEN-1:1]};
        end
        fin_prod_s = neg_dw(neg_q, acc_step_s);
        case (op_q)
            OP_MUL:                       fin_res_s = fin_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res_s = fin_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res_s = neg_w(neg_q, acc_step_s[XLEN-1:0]);
            OP_REM, OP_REMU:              fin_res_s = neg_w(rem_neg_q, acc_step_s[2*XLEN-1:XLEN]);
            default:                      fin_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        rem_neg_d   = rem_neg_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        valid_d     = 1'b0;
        we_out_d    = 1'b0;
        result_d    = result_q;
        waddr_out_d = waddr_out_q;
        if (ex_flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mdu_s) begin
                        op_d      = op_in_s;
                        a_d       = a_mag_s;
                        b_d       = b_mag_s;
                        neg_d     = a_neg_s ^ b_neg_s;
                        rem_neg_d = a_neg_s;
                        waddr_d   = id_ex_reg_reg_waddr_i;
                        we_d      = id_ex_reg_reg_we_i;
                        cnt_d     = 5'd0;
                        acc_d     = op_in_s[2] ? {{XLEN{1'b0}}, a_mag_s} : {{XLEN{1'b0}}, b_mag_s};
                        if (special_s) begin
                            state_d     = S_DONE;
                            valid_d     = 1'b1;
                            result_d    = special_res_s;
                            waddr_out_d = id_ex_reg_reg_waddr_i;
                            we_out_d    = id_ex_reg_reg_we_i;
                        end else begin
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = acc_step_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d     = S_DONE;
                        valid_d     = 1'b1;
                        result_d    = fin_res_s;
                        waddr_out_d = waddr_q;
                        we_out_d    = we_q;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            a_q         <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            acc_q       <= {(2*XLEN){1'b0}};
            cnt_q       <= 5'd0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            waddr_q     <= 5'd0;
            we_q        <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= {XLEN{1'b0}};
            waddr_out_q <= 5'd0;
            we_out_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            waddr_out_q <= waddr_out_d;
            we_out_q    <= we_out_d;
        end
    end

    // Stall must drop in DONE so the op held in ID/EX is not re-issued.
    assign ex_mdu_stall_o     = (((state_q == S_IDLE) & is_mdu_s) | (state_q == S_CALC)) & ~ex_flush_i;
    assign ex_mdu_busy_o      = (state_q == S_CALC);
    assign ex_mdu_valid_o     = valid_q;
    assign ex_mdu_result_o    = result_q;
    assign ex_mdu_reg_waddr_o = waddr_out_q;
    assign ex_mdu_reg_we_o    = we_out_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu: arithmetic, special cases,
// timing, flush, reset and back-to-back issue.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  ctrl_i, waddr_i;
    logic        we_i, flush_i;
    logic        stall_o, busy_o, valid_o, we_o;
    logic [31:0] result_o;
    logic [4:0]  waddr_o;

    int total = 0;
    int bad   = 0;

    int          obs_stalls, obs_busy, obs_vcyc;
    logic [31:0] obs_res, obs_res_after;
    logic [4:0]  obs_wa;
    logic        obs_we, obs_stall_done, obs_valid_after;

    always #5 clk = ~clk;

    ex_mdu dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .id_ex_reg_op_a_i      (op_a_i),
        .id_ex_reg_op_b_i      (op_b_i),
        .id_ex_reg_ALUctrl_i   (ctrl_i),
        .id_ex_reg_reg_waddr_i (waddr_i),
        .id_ex_reg_reg_we_i    (we_i),
        .ex_flush_i            (flush_i),
        .ex_mdu_stall_o        (stall_o),
        .ex_mdu_busy_o         (busy_o),
        .ex_mdu_valid_o        (valid_o),
        .ex_mdu_result_o       (result_o),
        .ex_mdu_reg_waddr_o    (waddr_o),
        .ex_mdu_reg_we_o       (we_o)
    );

    // Present one op, hold it until the result beat, record observations.
    task automatic run_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic we);
        int cyc;
        bit got;
        cyc = 0; got = 1'b0;
        obs_stalls = 0; obs_busy = 0; obs_vcyc = -1;
        obs_res = 32'd0; obs_wa = 5'd0; obs_we = 1'b0; obs_stall_done = 1'b1;
        ctrl_i = ctrl; op_a_i = a; op_b_i = b; waddr_i = wa; we_i = we;
        #1;
        while (!got && cyc < 60) begin
            if (valid_o) begin
                got = 1'b1;
                obs_vcyc = cyc; obs_res = result_o; obs_wa = waddr_o;
                obs_we = we_o; obs_stall_done = stall_o;
            end else begin
                if (stall_o) obs_stalls++;
                if (busy_o) obs_busy++;
                cyc++;
                @(negedge clk); #1;
            end
        end
        @(negedge clk); #1;
        obs_valid_after = valid_o;
        obs_res_after   = result_o;
        ctrl_i = 5'd0; op_a_i = 32'd0; op_b_i = 32'd0; waddr_i = 5'd0; we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; ctrl_i = 5'd0; op_a_i = 32'd0; op_b_i = 32'd0;
        waddr_i = 5'd0; we_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
        total++; if (waddr_o !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%h exp=0", waddr_o); end
        total++; if (we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we_o); end
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_mul();
        run_op(5'd16, 32'd7, 32'd6, 5'd3, 1'b1);
        total++; if (obs_res !== 32'd42) begin bad++; $display("FAIL mul_result got=%h exp=%h", obs_res, 32'd42); end
        total++; if (obs_wa !== 5'd3) begin bad++; $display("FAIL mul_waddr got=%0d exp=3", obs_wa); end
        total++; if (obs_we !== 1'b1) begin bad++; $display("FAIL mul_we got=%b exp=1", obs_we); end
        total++; if (obs_stalls != 33) begin bad++; $display("FAIL mul_stall_cycles got=%0d exp=33", obs_stalls); end
        total++; if (obs_vcyc != 33) begin bad++; $display("FAIL mul_valid_cycle got=%0d exp=33", obs_vcyc); end
        total++; if (obs_busy != 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=32", obs_busy); end
        total++; if (obs_stall_done !== 1'b0) begin bad++; $display("FAIL mul_stall_in_done got=%b exp=0", obs_stall_done); end
        total++; if (obs_valid_after !== 1'b0) begin bad++; $display("FAIL mul_valid_one_cycle got=%b exp=0", obs_valid_after); end
        total++; if (obs_res_after !== 32'd42) begin bad++; $display("FAIL mul_result_hold got=%h exp=%h", obs_res_after, 32'd42); end
        total++; if (we_o !== 1'b0) begin bad++; $display("FAIL mul_we_after got=%b exp=0", we_o); end
    endtask

    task automatic test_mulh();
        logic [4:0]  ctl [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] ex [3];
        ctl[0] = 5'd17; va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; ex[0] = 32'h00000000;
        ctl[1] = 5'd19; va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; ex[1] = 32'hFFFFFFFE;
        ctl[2] = 5'd18; va[2] = 32'hFFFFFFFF; vb[2] = 32'h00000002; ex[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            run_op(ctl[i], va[i], vb[i], 5'd4, 1'b1);
            total++;
            if (obs_res !== ex[i]) begin
                bad++; $display("FAIL mulh_vec%0d got=%h exp=%h", i, obs_res, ex[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [4:0]  ctl [4];
        logic [31:0] va [4];
        logic [31:0] ex [4];
        logic [31:0] vb [4];
        logic        vwe [4];
        ctl[0] = 5'd20; va[0] = 32'hFFFFFFF9; vb[0] = 32'd2; ex[0] = 32'hFFFFFFFD; vwe[0] = 1'b1;
        ctl[1] = 5'd22; va[1] = 32'hFFFFFFF9; vb[1] = 32'd2; ex[1] = 32'hFFFFFFFF; vwe[1] = 1'b1;
        ctl[2] = 5'd21; va[2] = 32'd100;      vb[2] = 32'd7; ex[2] = 32'd14;       vwe[2] = 1'b1;
        ctl[3] = 5'd23; va[3] = 32'd100;      vb[3] = 32'd7; ex[3] = 32'd2;        vwe[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(ctl[i], va[i], vb[i], 5'(i + 20), vwe[i]);
            total++;
            if (obs_res !== ex[i]) begin
                bad++; $display("FAIL div_vec%0d got=%h exp=%h", i, obs_res, ex[i]);
            end
            total++;
            if (obs_wa !== 5'(i + 20) || obs_we !== vwe[i]) begin
                bad++; $display("FAIL div_wb%0d got=%0d/%b exp=%0d/%b", i, obs_wa, obs_we, i + 20, vwe[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [4:0]  ctl [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] ex [3];
        ctl[0] = 5'd20; va[0] = 32'd5;        vb[0] = 32'd0;        ex[0] = 32'hFFFFFFFF;
        ctl[1] = 5'd23; va[1] = 32'd5;        vb[1] = 32'd0;        ex[1] = 32'd5;
        ctl[2] = 5'd20; va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; ex[2] = 32'h80000000;
        for (int i = 0; i < 3; i++) begin
            run_op(ctl[i], va[i], vb[i], 5'd7, 1'b1);
            total++;
            if (obs_res !== ex[i]) begin
                bad++; $display("FAIL special_vec%0d got=%h exp=%h", i, obs_res, ex[i]);
            end
            total++;
            if (obs_vcyc != 1 || obs_stalls != 1) begin
                bad++; $display("FAIL special_timing%0d got=valid@%0d stall=%0d exp=valid@1 stall=1", i, obs_vcyc, obs_stalls);
            end
        end
        run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, 5'd7, 1'b1);
        total++; if (obs_res !== 32'd0 || obs_vcyc != 1) begin
            bad++; $display("FAIL special_rem_ovf got=%h@%0d exp=0@1", obs_res, obs_vcyc);
        end
    endtask

    task automatic test_flush();
        int vcount;
        ctrl_i = 5'd20; op_a_i = 32'd1000; op_b_i = 32'd3; waddr_i = 5'd8; we_i = 1'b1;
        #1;
        repeat (10) @(negedge clk);
        #1;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b exp=1", busy_o); end
        flush_i = 1'b1; ctrl_i = 5'd0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall_drop got=%b exp=0", stall_o); end
        @(negedge clk); #1;
        flush_i = 1'b0;
        total++; if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL flush_idle got=busy%b stall%b exp=busy0 stall0", busy_o, stall_o);
        end
        vcount = 0;
        repeat (40) begin
            if (valid_o) vcount++;
            @(negedge clk); #1;
        end
        total++; if (vcount != 0) begin bad++; $display("FAIL flush_no_valid got=%0d exp=0", vcount); end
    endtask

    task automatic test_reset_mid();
        int vcount;
        ctrl_i = 5'd16; op_a_i = 32'd9; op_b_i = 32'd9; waddr_i = 5'd12; we_i = 1'b1;
        #1;
        repeat (20) @(negedge clk);
        #1;
        rst_n = 1'b0; ctrl_i = 5'd0;
        @(negedge clk); #1;
        total++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=busy%b valid%b stall%b exp=000", busy_o, valid_o, stall_o);
        end
        total++; if (result_o !== 32'd0 || waddr_o !== 5'd0 || we_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_data got=%h/%0d/%b exp=0/0/0", result_o, waddr_o, we_o);
        end
        rst_n = 1'b1;
        vcount = 0;
        repeat (40) begin
            if (valid_o) vcount++;
            @(negedge clk); #1;
        end
        total++; if (vcount != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", vcount); end
    endtask

    task automatic test_non_mdu();
        logic [4:0] codes [4];
        int act;
        codes[0] = 5'd0; codes[1] = 5'd15; codes[2] = 5'd24; codes[3] = 5'd31;
        for (int i = 0; i < 4; i++) begin
            ctrl_i = codes[i]; op_a_i = 32'd5; op_b_i = 32'd0; we_i = 1'b1;
            act = 0;
            repeat (13) begin
                #1;
                if (stall_o || busy_o || valid_o) act++;
                @(negedge clk);
            end
            total++;
            if (act != 0) begin bad++; $display("FAIL non_mdu_ctrl%0d got=%0d active exp=0", codes[i], act); end
        end
        ctrl_i = 5'd0; #1;
    endtask

    task automatic test_back_to_back();
        run_op(5'd21, 32'd100, 32'd7, 5'd9, 1'b1);
        total++; if (obs_res !== 32'd14) begin bad++; $display("FAIL b2b_first got=%h exp=%h", obs_res, 32'd14); end
        run_op(5'd16, 32'd7, 32'd6, 5'd10, 1'b1);
        total++; if (obs_res !== 32'd42 || obs_vcyc != 33) begin
            bad++; $display("FAIL b2b_second got=%h@%0d exp=%h@33", obs_res, obs_vcyc, 32'd42);
        end
        total++; if (obs_wa !== 5'd10) begin bad++; $display("FAIL b2b_waddr got=%0d exp=10", obs_wa); end
        run_op(5'd21, 32'd9, 32'd0, 5'd11, 1'b1);
        run_op(5'd19, 32'h00010000, 32'h00010000, 5'd12, 1'b1);
        total++; if (obs_res !== 32'd1 || obs_vcyc != 33) begin
            bad++; $display("FAIL b2b_after_special got=%h@%0d exp=%h@33", obs_res, obs_vcyc, 32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_non_mdu();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
